// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the IF stage: widths, reset/bubble constants,
// fetch FSM encoding and the IF/ID payload layout.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_BUF     = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold keeps contents, flush loads a bubble,
// otherwise the incoming instruction is captured as valid.
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            valid_o
);

    if_id_t if_id_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id_q <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
        end else if (hold_i) begin
            if_id_q <= if_id_q;
        end else if (flush_i) begin
            if_id_q <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
        end else begin
            if_id_q <= '{instr: instr_i, pc4: pc4_i, valid: 1'b1};
        end
    end

    assign instr_o = if_id_q.instr;
    assign pc4_o   = if_id_q.pc4;
    assign valid_o = if_id_q.valid;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC, instruction-memory request handshake, stall buffering,
// branch/jump redirect (including redirect while a fetch is outstanding) and IF/ID.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_stall_i,
    input  logic            stall_hold_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic            if_id_valid_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_q;
    logic [XLEN-1:0] buf_q;

    logic stall;
    logic ifid_flush;
    logic ifid_src_buf;
    logic pc_adv;
    logic pc_redir;
    logic pc_pend;
    logic buf_we;
    logic pend_we;

    assign stall = pc_stall_i | stall_hold_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (stall && imem_ready_i) begin
                    state_d = S_BUF;
                end else if (!stall && redirect_i && !imem_ready_i) begin
                    state_d = S_DISCARD;
                end
            end
            S_BUF: begin
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (imem_ready_i) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath controls; a stalled cycle never redirects, the request in flight still completes.
    always_comb begin
        ifid_flush   = 1'b1;
        ifid_src_buf = 1'b0;
        pc_adv       = 1'b0;
        pc_redir     = 1'b0;
        pc_pend      = 1'b0;
        buf_we       = 1'b0;
        pend_we      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (stall) begin
                    buf_we = imem_ready_i;
                end else if (redirect_i) begin
                    pc_redir = imem_ready_i;
                    pend_we  = !imem_ready_i;
                end else if (imem_ready_i) begin
                    ifid_flush = 1'b0;
                    pc_adv     = 1'b1;
                end
            end
            S_BUF: begin
                if (!stall) begin
                    if (redirect_i) begin
                        pc_redir = 1'b1;
                    end else begin
                        ifid_flush   = 1'b0;
                        ifid_src_buf = 1'b1;
                        pc_adv       = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                pend_we = !stall && redirect_i;
                if (imem_ready_i) begin
                    pc_redir = !stall && redirect_i;
                    pc_pend  = !(!stall && redirect_i);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
            buf_q  <= '0;
        end else begin
            if (pc_redir) begin
                pc_q <= redirect_pc_i;
            end else if (pc_pend) begin
                pc_q <= pend_q;
            end else if (pc_adv) begin
                pc_q <= pc_plus4(pc_q);
            end
            if (pend_we) begin
                pend_q <= redirect_pc_i;
            end
            if (buf_we) begin
                buf_q <= imem_data_i;
            end
        end
    end

    // Request drops immediately on reset so an abandoned fetch never lingers.
    assign imem_req_o  = !rst_i && (state_q != S_BUF);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;

    if_fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (stall),
        .flush_i (ifid_flush),
        .instr_i (ifid_src_buf ? buf_q : imem_data_i),
        .pc4_i   (pc_plus4(pc_q)),
        .instr_o (if_id_instr_o),
        .pc4_o   (if_id_pc4_o),
        .valid_o (if_id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table plus a hand-written
// asynchronous-reset-during-discard sequence.
module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        pc_stall_i = 1'b0;
    logic        stall_hold_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] pc_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;

    int checks = 0;
    int failures = 0;

    if_fetch_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_stall_i    (pc_stall_i),
        .stall_hold_i  (stall_hold_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_data_i   (imem_data_i),
        .pc_o          (pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        pc_stall;
        logic        stall_hold;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'h8C00_0000 ^ a;
    endfunction

    task automatic add(input logic st, input logic hd, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] d, input logic ereq,
                       input logic [31:0] eaddr, input logic [31:0] einstr,
                       input logic [31:0] epc4, input logic evalid, input logic [31:0] epc);
        vec_t v;
        v.pc_stall = st;   v.stall_hold = hd; v.redirect = rd; v.rpc = rpc;
        v.ready = rdy;     v.data = d;        v.exp_req = ereq; v.exp_addr = eaddr;
        v.exp_instr = einstr; v.exp_pc4 = epc4; v.exp_valid = evalid; v.exp_pc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // st hd rd rpc   rdy data  | req addr | instr pc4 valid | pc
        add(0,0,0,32'h0,1,dat(32'h00), 1,32'h00, dat(32'h00),32'h04,1, 32'h04);
        add(0,0,0,32'h0,1,dat(32'h04), 1,32'h04, dat(32'h04),32'h08,1, 32'h08);
        add(0,0,0,32'h0,1,dat(32'h08), 1,32'h08, dat(32'h08),32'h0C,1, 32'h0C);
        add(0,0,0,32'h0,1,dat(32'h0C), 1,32'h0C, dat(32'h0C),32'h10,1, 32'h10);
        // stall with ready at 0x10: buffered, IF/ID held; redirect under stall dropped
        add(1,0,0,32'h0,1,dat(32'h10), 1,32'h10, dat(32'h0C),32'h10,1, 32'h10);
        add(0,1,1,32'h99C,1,32'h0BAD,  0,32'h10, dat(32'h0C),32'h10,1, 32'h10);
        add(0,0,0,32'h0,0,32'h0,       0,32'h10, dat(32'h10),32'h14,1, 32'h14);
        add(0,0,0,32'h0,1,dat(32'h14), 1,32'h14, dat(32'h14),32'h18,1, 32'h18);
        // wait state: bubble
        add(0,0,0,32'h0,0,32'h0,       1,32'h18, 32'h0,32'h0,0,        32'h18);
        add(0,0,0,32'h0,1,dat(32'h18), 1,32'h18, dat(32'h18),32'h1C,1, 32'h1C);
        add(0,0,0,32'h0,1,dat(32'h1C), 1,32'h1C, dat(32'h1C),32'h20,1, 32'h20);
        // redirect to 0x40 while 0x20 outstanding
        add(0,0,1,32'h40,0,32'h0,      1,32'h20, 32'h0,32'h0,0,        32'h20);
        add(0,1,0,32'h0,0,32'h0,       1,32'h20, 32'h0,32'h0,0,        32'h20);
        add(0,0,0,32'h0,1,dat(32'h20), 1,32'h20, 32'h0,32'h0,0,        32'h40);
        add(0,0,0,32'h0,1,dat(32'h40), 1,32'h40, dat(32'h40),32'h44,1, 32'h44);
        // redirect and ready in the same cycle
        add(0,0,1,32'h80,1,dat(32'h44),1,32'h44, 32'h0,32'h0,0,        32'h80);
        add(0,0,0,32'h0,1,dat(32'h80), 1,32'h80, dat(32'h80),32'h84,1, 32'h84);
        // second redirect during discard overwrites the pending target
        add(0,0,1,32'h100,0,32'h0,     1,32'h84, 32'h0,32'h0,0,        32'h84);
        add(0,0,1,32'h200,0,32'h0,     1,32'h84, 32'h0,32'h0,0,        32'h84);
        add(0,0,0,32'h0,1,dat(32'h84), 1,32'h84, 32'h0,32'h0,0,        32'h200);
        add(0,0,0,32'h0,1,dat(32'h200),1,32'h200,dat(32'h200),32'h204,1,32'h204);
        // PC wrap at the top of the address space
        add(0,0,1,32'hFFFF_FFFC,1,dat(32'h204),1,32'h204,32'h0,32'h0,0,32'hFFFF_FFFC);
        add(0,0,0,32'h0,1,dat(32'hFFFF_FFFC),1,32'hFFFF_FFFC,dat(32'hFFFF_FFFC),32'h0,1,32'h0);
        add(0,0,0,32'h0,1,dat(32'h00), 1,32'h00, dat(32'h00),32'h04,1, 32'h04);

        // reset state
        #12;
        chk("rst_req",   -1, 32'(imem_req_o),    32'h0);
        chk("rst_pc",    -1, pc_o,               32'h0);
        chk("rst_valid", -1, 32'(if_id_valid_o), 32'h0);
        chk("rst_instr", -1, if_id_instr_o,      32'h0);
        chk("rst_pc4",   -1, if_id_pc4_o,        32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk_i);
            pc_stall_i    = vecs[i].pc_stall;
            stall_hold_i  = vecs[i].stall_hold;
            redirect_i    = vecs[i].redirect;
            redirect_pc_i = vecs[i].rpc;
            imem_ready_i  = vecs[i].ready;
            imem_data_i   = vecs[i].data;
            #1;
            chk("req",  i, 32'(imem_req_o), 32'(vecs[i].exp_req));
            chk("addr", i, imem_addr_o,     vecs[i].exp_addr);
            @(posedge clk_i);
            #1;
            chk("instr", i, if_id_instr_o,      vecs[i].exp_instr);
            chk("pc4",   i, if_id_pc4_o,        vecs[i].exp_pc4);
            chk("valid", i, 32'(if_id_valid_o), 32'(vecs[i].exp_valid));
            chk("pc",    i, pc_o,               vecs[i].exp_pc);
        end

        // async reset while a redirect discard is outstanding
        @(negedge clk_i);
        redirect_i = 1'b1; redirect_pc_i = 32'h300; imem_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        chk("disc_req",  100, 32'(imem_req_o), 32'h1);
        chk("disc_addr", 100, imem_addr_o,     32'h4);
        #1;
        rst_i = 1'b1;
        #1;
        chk("arst_req",   101, 32'(imem_req_o),    32'h0);
        chk("arst_pc",    101, pc_o,               32'h0);
        chk("arst_valid", 101, 32'(if_id_valid_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        imem_ready_i = 1'b1; imem_data_i = dat(32'h0);
        #1;
        chk("post_req",  102, 32'(imem_req_o), 32'h1);
        chk("post_addr", 102, imem_addr_o,     32'h0);
        @(posedge clk_i);
        #1;
        chk("post_instr", 102, if_id_instr_o,      dat(32'h0));
        chk("post_valid", 102, 32'(if_id_valid_o), 32'h1);
        chk("post_pc4",   102, if_id_pc4_o,        32'h4);
        chk("post_pc",    102, pc_o,               32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
